imm_issue_ctrl: RTL and testbench
=================================

# imm_issue_ctrl

Sequencing front end for the immediate-extension datapath. It accepts fetched 32-bit instructions over a valid/ready handshake and classifies each by instruction[31:30]. At enqueue it computes the 64-bit sign-extended immediate and holds results in a 2-entry in-order queue until the execute stage accepts them. It sits between instruction fetch and the register-read/ALU stage and decouples fetch from execute back-pressure.

## Interface
- No parameters; depth fixed at 2, widths fixed at 32-bit instruction / 64-bit immediate.
- clock  input  1  rising-edge clock, sole clock domain
- reset_n  input  1  reset, synchronous, active-low
- flush  input  1  discard all queued entries (branch redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept this cycle
- in_instruction  input  32  instruction word
- out_valid  output  1  head entry valid
- out_ready  input  1  execute accepts head this cycle
- out_instruction  output  32  head instruction, unmodified
- out_imm  output  64  head sign-extended immediate
- out_format  output  2  head instruction[31:30]
- out_has_imm  output  1  head format carries an immediate

## Operation
- Format decode on instruction[31:30]:
  - 2'b11 (D): imm = sign-extend instruction[20:12] (9 bits).
  - 2'b10 (CB): imm = sign-extend instruction[23:5] (19 bits).
  - 2'b00 (B): imm = sign-extend instruction[25:0] (26 bits).
  - 2'b01: imm = 64'h0, has_imm = 0.
- The immediate is computed at enqueue and stored per entry. Outputs are driven from registers only.
- FSM states:
  - EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push → ONE.
  - ONE: push & ~pop → FULL; pop & ~push → EMPTY; push & pop → ONE. The new entry becomes head next cycle.
  - FULL: pop → ONE. Push is impossible because in_ready = 0.
- in_ready = (state != FULL). It is a function of registered state only and never depends on out_ready in the same cycle.
- out_valid = (state != EMPTY).
- Ordering is strict FIFO; no reordering or bypass.
- flush: next state EMPTY. flush overrides push and pop in the same cycle, and a simultaneous input is dropped.
- Head outputs are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset values: state EMPTY, out_valid 0, in_ready 1 from the cycle after reset_n is sampled low, out_instruction 0, out_imm 0, out_format 0, out_has_imm 0.
- Latency: an instruction pushed in cycle N appears with out_valid = 1 in cycle N+1 if the queue was empty.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.
- Reset asserted mid-operation behaves exactly as flush plus clearing all output registers. Entries are lost.
- After flush in cycle N: out_valid = 0 and in_ready = 1 in cycle N+1.

## Configuration
- BRANCH_SHIFT_EN
  - Defined: CB and B immediates are byte offsets, i.e. {sign-extended field, 2'b00} kept at 64 bits, with sign preserved. D immediates are unaffected.
  - Undefined: CB and B immediates are word offsets exactly as extended above.

## Test plan
- D-format: push 0xF85FF000 into an empty queue → next cycle out_valid = 1, out_format = 2'b11, out_has_imm = 1, out_imm = 0xFFFF_FFFF_FFFF_FFFF.
- B-format: push 0x17FFFFFF → out_imm = 0xFFFF_FFFF_FFFF_FFFF without BRANCH_SHIFT_EN, 0xFFFF_FFFF_FFFF_FFFC with it.
- CB-format and format 01:
  - Push 0xB4000040 → out_imm = 0x2 without the macro, 0x8 with it.
  - Push 0x40000000 → out_has_imm = 0, out_imm = 0.
- Back-pressure: out_ready = 0, offer A, B, C on consecutive cycles → A and B accepted, in_ready = 0 while C is held. Raise out_ready → A, B, C emerge in order with no duplication or loss.
- Flush: queue FULL, assert flush together with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the offered instruction never appears at the output.
- Reset: assert reset_n = 0 with the queue in ONE state → next cycle all outputs are at their reset values. After release, a push of 0xF85FF000 behaves as in the D-format test.

Source files
------------

// File: rtl/imm_issue_ctrl.sv
// imm_issue_ctrl: 2-entry in-order issue queue that decodes the instruction format
// and computes the 64-bit sign-extended immediate at enqueue time.
// Latency: an instruction pushed into an empty queue is presented at the head one cycle later.
// Backpressure: in_ready drops only when both entries are occupied; it never looks at out_ready.
//
// Ports: clock, reset_n (sync, active-low), flush;
//        in_valid / in_ready / in_instruction  (fetch side);
//        out_valid / out_ready / out_instruction / out_imm / out_format / out_has_imm  (execute side).
// Optional feature macro: BRANCH_SHIFT_EN -- CB and B immediates become byte offsets (field << 2).
module imm_issue_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_imm,
  output logic [1:0]  out_format,
  output logic        out_has_imm
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [1:0]  fmt;
    logic        has_imm;
  } entry_t;

  state_t state;
  entry_t head;   // oldest entry, drives the outputs directly
  entry_t tail;   // second entry, only meaningful in FULL
  entry_t enq;    // decoded form of the incoming instruction

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Decode once at enqueue so the head outputs are pure register values.
  always_comb begin
    enq         = '0;
    enq.instr   = in_instruction;
    enq.fmt     = in_instruction[31:30];
    enq.has_imm = 1'b1;
    case (in_instruction[31:30])
      2'b11: enq.imm = {{55{in_instruction[20]}}, in_instruction[20:12]};
`ifdef BRANCH_SHIFT_EN
      2'b10: enq.imm = {{43{in_instruction[23]}}, in_instruction[23:5], 2'b00};
      2'b00: enq.imm = {{36{in_instruction[25]}}, in_instruction[25:0], 2'b00};
`else
      2'b10: enq.imm = {{45{in_instruction[23]}}, in_instruction[23:5]};
      2'b00: enq.imm = {{38{in_instruction[25]}}, in_instruction[25:0]};
`endif
      default: begin
        enq.imm     = 64'h0;
        enq.has_imm = 1'b0;
      end
    endcase
  end

  // in_ready / out_valid are kept as their own flops, updated alongside the
  // state, so neither handshake output has decode logic in front of it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else if (flush) begin
      // Entry payloads are left as-is; out_valid=0 makes them invisible.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= enq;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head leaves and the new entry takes its place in the same cycle.
            head <= enq;
          end else if (push) begin
            tail     <= enq;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_instruction = head.instr;
  assign out_imm         = head.imm;
  assign out_format      = head.fmt;
  assign out_has_imm     = head.has_imm;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
module tb_imm_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_imm;
  logic [1:0]  out_format;
  logic        out_has_imm;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [1:0]  fmt;
    logic        has;
  } ment_t;

  ment_t mq[$];

  imm_issue_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_imm        (out_imm),
    .out_format     (out_format),
    .out_has_imm    (out_has_imm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference decode: extract the field arithmetically, then fold values
  // at or above half-range into negatives (two's complement in 64 bits).
  function automatic ment_t make_entry(input logic [31:0] instr);
    ment_t e;
    logic [63:0] u;
    int lo;
    int n;
    e.instr = instr;
    e.fmt   = instr[31:30];
    e.has   = 1'b1;
    lo = 0;
    n  = 0;
    if (instr[31:30] == 2'b11) begin lo = 12; n = 9; end
    else if (instr[31:30] == 2'b10) begin lo = 5; n = 19; end
    else if (instr[31:30] == 2'b00) begin lo = 0; n = 26; end
    if (n == 0) begin
      e.imm = 64'h0;
      e.has = 1'b0;
    end else begin
      u = ({32'h0, instr} >> lo) & ((64'd1 << n) - 64'd1);
      if (u >= (64'd1 << (n - 1))) u = u - (64'd1 << n);
`ifdef BRANCH_SHIFT_EN
      if (n != 9) u = u * 64'd4;
`endif
      e.imm = u;
    end
    return e;
  endfunction

  // Advance one clock, updating the reference queue from the inputs driven
  // during the cycle; returns at the following negedge, the sampling point.
  task automatic step();
    bit push;
    bit pop;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    @(posedge clock);
    if (!reset_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(make_entry(in_instruction));
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_instruction = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_instruction !== 32'h0) begin fails++; $display("FAIL reset_instr got=%h exp=0", out_instruction); end
    tests++; if (out_imm !== 64'h0) begin fails++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
    tests++; if (out_format !== 2'b00) begin fails++; $display("FAIL reset_format got=%b exp=00", out_format); end
    tests++; if (out_has_imm !== 1'b0) begin fails++; $display("FAIL reset_has_imm got=%b exp=0", out_has_imm); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_formats();
    logic [31:0] instrs [4];
    logic [63:0] imms   [4];
    logic        hass   [4];
    instrs[0] = 32'hF85FF000; imms[0] = 64'hFFFF_FFFF_FFFF_FFFF; hass[0] = 1'b1;
`ifdef BRANCH_SHIFT_EN
    instrs[1] = 32'h17FFFFFF; imms[1] = 64'hFFFF_FFFF_FFFF_FFFC; hass[1] = 1'b1;
    instrs[2] = 32'hB4000040; imms[2] = 64'h8;                   hass[2] = 1'b1;
`else
    instrs[1] = 32'h17FFFFFF; imms[1] = 64'hFFFF_FFFF_FFFF_FFFF; hass[1] = 1'b1;
    instrs[2] = 32'hB4000040; imms[2] = 64'h2;                   hass[2] = 1'b1;
`endif
    instrs[3] = 32'h40000000; imms[3] = 64'h0;                   hass[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      in_valid = 1'b1;
      in_instruction = instrs[i];
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fmt%0d_valid got=%b exp=1", i, out_valid); end
      tests++; if (out_instruction !== instrs[i]) begin fails++; $display("FAIL fmt%0d_instr got=%h exp=%h", i, out_instruction, instrs[i]); end
      tests++; if (out_format !== instrs[i][31:30]) begin fails++; $display("FAIL fmt%0d_format got=%b exp=%b", i, out_format, instrs[i][31:30]); end
      tests++; if (out_has_imm !== hass[i]) begin fails++; $display("FAIL fmt%0d_has_imm got=%b exp=%b", i, out_has_imm, hass[i]); end
      tests++; if (out_imm !== imms[i]) begin fails++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, out_imm, imms[i]); end
      out_ready = 1'b1;
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fmt%0d_drain got=%b exp=0", i, out_valid); end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] offers [3];
    logic [31:0] seen[$];
    int idx;
    offers[0] = 32'hF8100000; offers[1] = 32'hB4000020; offers[2] = 32'h00000123;
    idle_inputs();
    idx = 0;
    // Offer A, B, C with execute stalled.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instruction = offers[idx];
      if (in_ready) idx++;
      step();
    end
    tests++; if (idx !== 2) begin fails++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    // Release execute and keep offering C until taken.
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen.push_back(out_instruction);
      if (idx < 3) begin
        in_valid = 1'b1;
        in_instruction = offers[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      in_valid = 1'b0;
      if (seen.size() == 3 && !out_valid) break;
    end
    tests++; if (seen.size() !== 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", seen.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < seen.size()) begin
        tests++; if (seen[k] !== offers[k]) begin fails++; $display("FAIL bp_order%0d got=%h exp=%h", k, seen[k], offers[k]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_instruction = 32'hC0001000 + c;
      step();
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefull got=%b exp=0", in_ready); end
    flush = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'hF85FF000;
    step();
    idle_inputs();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost%0d got=%b exp=0 instr=%h", c, out_valid, out_instruction); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1'b1;
    in_instruction = 32'hB4000040;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_one got=%b exp=1", out_valid); end
    reset_n = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
    tests++; if (out_instruction !== 32'h0) begin fails++; $display("FAIL rmid_instr got=%h exp=0", out_instruction); end
    tests++; if (out_imm !== 64'h0) begin fails++; $display("FAIL rmid_imm got=%h exp=0", out_imm); end
    tests++; if (out_format !== 2'b00 || out_has_imm !== 1'b0) begin fails++; $display("FAIL rmid_fmt got=%b/%b exp=00/0", out_format, out_has_imm); end
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'hF85FF000;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_format !== 2'b11 || out_has_imm !== 1'b1) begin fails++; $display("FAIL rmid_d_ctl got=%b/%b/%b exp=1/11/1", out_valid, out_format, out_has_imm); end
    tests++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL rmid_d_imm got=%h exp=ffffffffffffffff", out_imm); end
    out_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tests++; if (out_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd%0d_valid got=%b exp=%b", c, out_valid, mq.size() != 0); end
      tests++; if (in_ready !== (mq.size() < 2)) begin fails++; $display("FAIL rnd%0d_ready got=%b exp=%b", c, in_ready, mq.size() < 2); end
      if (mq.size() != 0) begin
        tests++; if (out_instruction !== mq[0].instr) begin fails++; $display("FAIL rnd%0d_instr got=%h exp=%h", c, out_instruction, mq[0].instr); end
        tests++; if (out_imm !== mq[0].imm) begin fails++; $display("FAIL rnd%0d_imm got=%h exp=%h", c, out_imm, mq[0].imm); end
        tests++; if (out_format !== mq[0].fmt || out_has_imm !== mq[0].has) begin fails++; $display("FAIL rnd%0d_fmt got=%b/%b exp=%b/%b", c, out_format, out_has_imm, mq[0].fmt, mq[0].has); end
      end
      in_valid       = ($urandom_range(0, 99) < 65);
      out_ready      = ($urandom_range(0, 99) < 55);
      flush          = ($urandom_range(0, 99) < 4);
      in_instruction = $urandom;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
